spi: RTL and testbench

Single-clock SPI master that shifts a 16-bit word out on `mosi` while shifting 16 bits in from `miso`. It runs in mode 0 (CPOL=0, CPHA=0), MSB first, with an active-low chip select. It sits between on-chip control logic and one external SPI slave. The received word is presented on a held parallel output once the frame completes.

---
 rtl/spi_pkg.sv | 9 +
 rtl/spi_clk_div.sv | 37 +++
 rtl/spi.sv | 90 +++++++++
 tb/tb_spi.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// SPI master shared types.
// Holds the FSM state encoding used by the spi top.
package spi_pkg;
  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } spi_state_t;
endpackage

// File: rtl/spi_clk_div.sv
// SCLK divider: counts CLK_DIV cycles per half-period while en is high.
// Ports: clk, reset, en in; rise_tick, fall_tick single-cycle pulses out.
module spi_clk_div #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic rise_tick,
  output logic fall_tick
);
  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          phase;
  logic          wrap;

  assign wrap      = en && (cnt == CW'(CLK_DIV - 1));
  assign rise_tick = wrap && !phase;
  assign fall_tick = wrap && phase;

  // phase mirrors the sclk level; cleared whenever disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (wrap) begin
      cnt   <= '0;
      phase <= !phase;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/spi.sv
// Mode-0 SPI master, MSB first, active-low cs, WIDTH-bit frames.
// Ports: clk, reset, start_transfer, data_to_tx, miso in; data_rx, sclk, mosi, cs out.
module spi
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 8,
  parameter int WIDTH   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_transfer,
  input  logic [WIDTH-1:0] data_to_tx,
  output logic [WIDTH-1:0] data_rx,
  output logic             sclk,
  input  logic             miso,
  output logic             mosi,
  output logic             cs
);
  localparam int BW = $clog2(WIDTH);

  spi_state_t       state;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic [BW-1:0]    bit_cnt;
  logic             rise_tick;
  logic             fall_tick;

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .en       (state == XFER),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
      data_rx <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs      <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          sclk <= 1'b0;
          if (start_transfer) begin
            tx_sr   <= data_to_tx;
            bit_cnt <= '0;
            cs      <= 1'b0;
            mosi    <= data_to_tx[WIDTH-1];
            state   <= XFER;
          end else begin
            cs   <= 1'b1;
            mosi <= 1'b0;
          end
        end
        XFER: begin
          if (rise_tick) begin
            sclk  <= 1'b1;
            rx_sr <= {rx_sr[WIDTH-2:0], miso};
          end
          if (fall_tick) begin
            sclk <= 1'b0;
            if (bit_cnt == BW'(WIDTH - 1)) begin
              cs      <= 1'b1;
              mosi    <= 1'b0;
              data_rx <= rx_sr;
              state   <= DONE;
            end else begin
              tx_sr   <= {tx_sr[WIDTH-2:0], 1'b0};
              mosi    <= tx_sr[WIDTH-2];
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        DONE: begin
          if (!start_transfer)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi.sv
// Directed self-checking bench for the spi master.
// Records each frame cycle by cycle and compares against hand values.
module tb_spi;
  logic        clk;
  logic        reset;
  logic        start_transfer;
  logic [15:0] data_to_tx;
  logic [15:0] data_rx;
  logic        sclk;
  logic        miso;
  logic        mosi;
  logic        cs;
  logic        loop_en;
  logic        miso_fix;

  int n_cmp;
  int n_err;

  int          rises;
  int          hi_min, hi_max, lo_min, lo_max;
  logic [31:0] seq;
  int          csl;
  int          ones;

  assign miso = loop_en ? mosi : miso_fix;

  spi dut (
    .clk           (clk),
    .reset         (reset),
    .start_transfer(start_transfer),
    .data_to_tx    (data_to_tx),
    .data_rx       (data_rx),
    .sclk          (sclk),
    .miso          (miso),
    .mosi          (mosi),
    .cs            (cs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one frame, samples 300 negedges and gathers statistics.
  task automatic run_frame(input logic [15:0] word, input int hold,
                           input int chg_at, input logic [15:0] chg_val);
    logic prev;
    int   run;
    prev   = 1'b0;
    run    = 0;
    rises  = 0;
    hi_min = 999; hi_max = 0;
    lo_min = 999; lo_max = 0;
    seq    = '0;
    csl    = 0;
    ones   = 0;
    @(negedge clk);
    data_to_tx     = word;
    start_transfer = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (sclk && !prev) begin
        rises++;
        seq = {seq[30:0], mosi};
        if (run < lo_min) lo_min = run;
        if (run > lo_max) lo_max = run;
        run = 0;
      end else if (!sclk && prev) begin
        if (run < hi_min) hi_min = run;
        if (run > hi_max) hi_max = run;
        run = 0;
      end
      run++;
      prev = sclk;
      if (!cs) csl++;
      if (mosi) ones++;
      if (n + 1 == hold) start_transfer = 1'b0;
      if (n == chg_at) data_to_tx = chg_val;
    end
    start_transfer = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    loop_en        = 1'b1;
    miso_fix       = 1'b0;
    start_transfer = 1'b0;
    data_to_tx     = 16'h0000;
    reset          = 1'b1;
    #1;
    chk("rst_cs", 32'(cs), 32'h1);
    chk("rst_sclk", 32'(sclk), 32'h0);
    chk("rst_mosi", 32'(mosi), 32'h0);
    chk("rst_rx", 32'(data_rx), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_cs", 32'(cs), 32'h1);

    run_frame(16'hA5A5, 10, -1, 16'h0000);
    chk("a5_rises", 32'(rises), 32'd16);
    chk("a5_hi_min", 32'(hi_min), 32'd8);
    chk("a5_hi_max", 32'(hi_max), 32'd8);
    chk("a5_lo_min", 32'(lo_min), 32'd8);
    chk("a5_lo_max", 32'(lo_max), 32'd8);
    chk("a5_mosi", seq, 32'h0000A5A5);
    chk("a5_cs_low", 32'(csl), 32'd256);
    chk("a5_rx", 32'(data_rx), 32'h0000A5A5);
    chk("a5_cs_end", 32'(cs), 32'h1);

    run_frame(16'h1234, 18, -1, 16'h0000);
    chk("f2_rises", 32'(rises), 32'd16);
    chk("f2_cs_low", 32'(csl), 32'd256);
    chk("f2_rx", 32'(data_rx), 32'h00001234);

    run_frame(16'h8001, 299, -1, 16'h0000);
    chk("hold_rises", 32'(rises), 32'd16);
    chk("hold_cs_low", 32'(csl), 32'd256);
    chk("hold_rx", 32'(data_rx), 32'h00008001);

    run_frame(16'hA5A5, 10, 84, 16'hFFFF);
    chk("chg_mosi", seq, 32'h0000A5A5);
    chk("chg_rx", 32'(data_rx), 32'h0000A5A5);

    @(negedge clk);
    data_to_tx     = 16'h5A5A;
    start_transfer = 1'b1;
    repeat (128) @(negedge clk);
    start_transfer = 1'b0;
    chk("mid_cs_low", 32'(cs), 32'h0);
    chk("mid_rx_hold", 32'(data_rx), 32'h0000A5A5);
    reset = 1'b1;
    #1;
    chk("abort_cs", 32'(cs), 32'h1);
    chk("abort_sclk", 32'(sclk), 32'h0);
    chk("abort_mosi", 32'(mosi), 32'h0);
    chk("abort_rx", 32'(data_rx), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_abort_cs", 32'(cs), 32'h1);
    chk("post_abort_rx", 32'(data_rx), 32'h0);

    run_frame(16'h1234, 10, -1, 16'h0000);
    chk("ab_f_rises", 32'(rises), 32'd16);
    chk("ab_f_rx", 32'(data_rx), 32'h00001234);

    loop_en  = 1'b0;
    miso_fix = 1'b1;
    run_frame(16'h0000, 10, -1, 16'h0000);
    chk("fix_rx", 32'(data_rx), 32'h0000FFFF);
    chk("fix_mosi_ones", 32'(ones), 32'd0);
    chk("fix_rises", 32'(rises), 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
